game_ctrl: RTL



---
 rtl/game_pkg.sv | 23 ++
 rtl/click_edge.sv | 25 ++
 rtl/game_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared types for the battleship turn sequencer: FSM states and the board cell format.
package game_pkg;

  typedef logic [7:0] cell_t;

  localparam cell_t NO_CELL = 8'hFF;

  // Encoding is exported on the phase output for the display.
  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    PLACE   = 4'd1,
    PL_CHK  = 4'd2,
    READY   = 4'd3,
    FIRE    = 4'd4,
    SHOT    = 4'd5,
    RESULT  = 4'd6,
    DEFEND  = 4'd7,
    DEF_CHK = 4'd8,
    WIN     = 4'd9,
    LOSE    = 4'd10
  } state_t;

endpackage

// File: rtl/click_edge.sv
// Turns a registered mouse cell coordinate into a one-cycle click event:
// a real cell that differs from the cell seen in the previous cycle.
module click_edge
  import game_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] cor_i,
  output logic       evt_o
);

  cell_t prev_q;

  // previous-cycle coordinate
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= NO_CELL;
    end else begin
      prev_q <= cor_i;
    end
  end

  assign evt_o = (cor_i != NO_CELL) && (cor_i != prev_q);

endmodule

// File: rtl/game_ctrl.sv
// Battleship turn sequencer: ship placement against the player board, then
// alternating fire/defend turns over the opponent link until win or lose.
module game_ctrl
  import game_pkg::*;
#(
  parameter int SHIP_CELLS = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic [7:0] player_cor,
  input  logic [7:0] enemy_cor,
  input  logic       first_move,
  output logic [7:0] pl_addr,
  input  logic       pl_occ,
  output logic       pl_we,
  output logic       board_clr,
  output logic       shot_valid,
  output logic [7:0] shot_cor,
  input  logic       shot_ready,
  input  logic       res_valid,
  input  logic       res_hit,
  input  logic       opp_shot_valid,
  input  logic [7:0] opp_shot_cor,
  output logic       opp_res_valid,
  output logic       opp_res_hit,
  output logic [3:0] phase,
  output logic       win,
  output logic       lose
);

  localparam int CW = $clog2(SHIP_CELLS + 1);
  localparam logic [CW-1:0] FULL = CW'(SHIP_CELLS);
  localparam logic [CW-1:0] ONE  = CW'(1);

  state_t        state_q, state_d;
  cell_t         pl_addr_q, pl_addr_d;
  cell_t         shot_cor_q, shot_cor_d;
  logic [CW-1:0] placed_q, placed_d;
  logic [CW-1:0] enemy_hits_q, enemy_hits_d;
  logic [CW-1:0] own_hits_q, own_hits_d;
  logic [255:0]  fired_q, fired_d;
  logic          rd_wait_q, rd_wait_d;
  logic          board_clr_q, board_clr_d;
  logic          start_prev_q;
  logic          start_evt_s, pl_evt_s, en_evt_s;

  click_edge u_pl_edge (.clk(clk), .rst(rst), .cor_i(player_cor), .evt_o(pl_evt_s));
  click_edge u_en_edge (.clk(clk), .rst(rst), .cor_i(enemy_cor),  .evt_o(en_evt_s));

  // Reset to 1 so a button held through reset is not seen as a press.
  assign start_evt_s = start_btn & ~start_prev_q;

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pl_addr_q    <= 8'h00;
      shot_cor_q   <= 8'h00;
      placed_q     <= '0;
      enemy_hits_q <= '0;
      own_hits_q   <= '0;
      fired_q      <= '0;
      rd_wait_q    <= 1'b0;
      board_clr_q  <= 1'b0;
      start_prev_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      pl_addr_q    <= pl_addr_d;
      shot_cor_q   <= shot_cor_d;
      placed_q     <= placed_d;
      enemy_hits_q <= enemy_hits_d;
      own_hits_q   <= own_hits_d;
      fired_q      <= fired_d;
      rd_wait_q    <= rd_wait_d;
      board_clr_q  <= board_clr_d;
      start_prev_q <= start_btn;
    end
  end

  // next state, datapath updates and memory/reply strobes
  always_comb begin
    state_d       = state_q;
    pl_addr_d     = pl_addr_q;
    shot_cor_d    = shot_cor_q;
    placed_d      = placed_q;
    enemy_hits_d  = enemy_hits_q;
    own_hits_d    = own_hits_q;
    fired_d       = fired_q;
    rd_wait_d     = 1'b0;
    board_clr_d   = 1'b0;
    pl_we         = 1'b0;
    opp_res_valid = 1'b0;
    opp_res_hit   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_evt_s) begin
          board_clr_d  = 1'b1;
          placed_d     = '0;
          enemy_hits_d = '0;
          own_hits_d   = '0;
          fired_d      = '0;
          state_d      = PLACE;
        end
      end
      PLACE: begin
        if (pl_evt_s) begin
          pl_addr_d = player_cor;
          rd_wait_d = 1'b1;
          state_d   = PL_CHK;
        end
      end
      // The board read returns one cycle after the address, hence rd_wait_q.
      PL_CHK: begin
        if (!rd_wait_q) begin
          if (!pl_occ) begin
            pl_we    = 1'b1;
            placed_d = placed_q + ONE;
          end else begin
            placed_d = placed_q;
          end
          state_d = (placed_d == FULL) ? READY : PLACE;
        end
      end
      READY: begin
        if (start_evt_s) begin
          state_d = first_move ? FIRE : DEFEND;
        end
      end
      FIRE: begin
        if (en_evt_s && !fired_q[enemy_cor]) begin
          fired_d[enemy_cor] = 1'b1;
          shot_cor_d         = enemy_cor;
          state_d            = SHOT;
        end
      end
      SHOT: begin
        if (shot_ready) begin
          state_d = RESULT;
        end
      end
      RESULT: begin
        if (res_valid) begin
          if (res_hit) begin
            enemy_hits_d = enemy_hits_q + ONE;
            state_d      = (enemy_hits_d == FULL) ? WIN : FIRE;
          end else begin
            state_d = DEFEND;
          end
        end
      end
      DEFEND: begin
        if (opp_shot_valid) begin
          pl_addr_d = opp_shot_cor;
          rd_wait_d = 1'b1;
          state_d   = DEF_CHK;
        end
      end
      DEF_CHK: begin
        if (!rd_wait_q) begin
          opp_res_valid = 1'b1;
          opp_res_hit   = pl_occ;
          if (pl_occ) begin
            own_hits_d = own_hits_q + ONE;
            state_d    = (own_hits_d == FULL) ? LOSE : DEFEND;
          end else begin
            state_d = FIRE;
          end
        end
      end
      WIN, LOSE: begin
        if (start_evt_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign pl_addr    = pl_addr_q;
  assign shot_cor   = shot_cor_q;
  assign shot_valid = (state_q == SHOT);
  assign board_clr  = board_clr_q;
  assign phase      = state_q;
  assign win        = (state_q == WIN);
  assign lose       = (state_q == LOSE);

endmodule
